// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 scan sequencer: FSM encoding, scan-code
// constants, event payload layout and the discard-byte classifier.
package ps2_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,   // no prefix pending
      ST_PFX  = 2'd1,   // E0 and/or F0 prefix pending
      ST_GAP  = 2'd2    // one-cycle wait after a consume pulse
   } state_t;

   localparam logic [7:0] SC_EXT    = 8'hE0;
   localparam logic [7:0] SC_BRK    = 8'hF0;
   localparam logic [7:0] SC_LSHIFT = 8'h12;
   localparam logic [7:0] SC_RSHIFT = 8'h59;
   localparam logic [7:0] SC_CTRL   = 8'h14;
   localparam logic [7:0] SC_ALT    = 8'h11;

   // Event payload: {brk, ext, code}
   localparam int unsigned EV_CODE_W   = 8;
   localparam int unsigned EV_CODE_LSB = 0;
   localparam int unsigned EV_EXT_BIT  = 8;
   localparam int unsigned EV_BRK_BIT  = 9;
   localparam int unsigned EV_W        = 10;

   // Keyboard status/ack bytes that carry no key information
   function automatic logic is_discard(input logic [7:0] b);
      return (b == 8'hAA) || (b == 8'hFA) || (b == 8'hEE) ||
             (b == 8'hFE) || (b == 8'h00) || (b == 8'hFF);
   endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// Synchronous show-ahead event FIFO.
// Ports: clk, rst (async, active-high); push/din write; pop read;
//        full/empty from the registered occupancy count; head = oldest entry.
module ps2_evt_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] head
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             push_ok;
   logic             pop_ok;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign head    = mem[rd_ptr];
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;

   // Storage and pointers; DEPTH is a power of two so pointers wrap naturally
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
      end else begin
         if (push_ok) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (pop_ok) rd_ptr <= rd_ptr + AW'(1);
         count <= count + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
      end
   end

endmodule

// File: rtl/ps2_scan_sequencer.sv
// PS/2 scan sequencer: pops bytes from the ps2key receiver, decodes E0/F0
// prefixes, tracks shift/ctrl/alt, and queues {code,ext,brk} key events.
// Ports: clk, rst (async, active-high); rx_ready/rx_data/rx_overflow in,
//        rx_read_next pulse out; ev_valid/ev_ready/ev_code/ev_ext/ev_break
//        event stream; mod_shift/mod_ctrl/mod_alt; key_cnt; err pulse.
// Optional: PS2SEQ_REPEAT_FILTER_EN drops typematic repeats of the held key.
module ps2_scan_sequencer
   import ps2_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned CNT_W      = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             rx_ready,
   input  logic [7:0]       rx_data,
   input  logic             rx_overflow,
   output logic             rx_read_next,
   output logic             ev_valid,
   input  logic             ev_ready,
   output logic [7:0]       ev_code,
   output logic             ev_ext,
   output logic             ev_break,
   output logic             mod_shift,
   output logic             mod_ctrl,
   output logic             mod_alt,
   output logic [CNT_W-1:0] key_cnt,
   output logic             err
);

   state_t          state;
   logic            ext;
   logic            brk;
   logic            lshift;
   logic            rshift;
   logic            fifo_full;
   logic            fifo_empty;
   logic [EV_W-1:0] fifo_head;
   logic [EV_W-1:0] push_data;
   logic            byte_ext;
   logic            byte_brk;
   logic            byte_key;
   logic            byte_err;
   logic            take;
   logic            push;
   logic            pop;
   logic            rpt_drop;

   // Byte classification against the current prefix flags
   assign byte_ext  = (rx_data == SC_EXT);
   assign byte_brk  = (rx_data == SC_BRK);
   assign byte_key  = !byte_ext && !byte_brk && !is_discard(rx_data);
   assign byte_err  = (byte_ext && (ext || brk)) || (byte_brk && brk);

   // A key byte is held off while the FIFO is full; prefixes never stall
   assign take      = (state != ST_GAP) && rx_ready && !(byte_key && fifo_full);
   assign push      = take && byte_key && !rpt_drop;
   assign push_data = {brk, ext, rx_data};
   assign pop       = ev_valid && ev_ready;

   assign ev_valid  = !fifo_empty;
   assign ev_code   = fifo_head[EV_CODE_LSB +: EV_CODE_W];
   assign ev_ext    = fifo_head[EV_EXT_BIT];
   assign ev_break  = fifo_head[EV_BRK_BIT];
   assign mod_shift = lshift || rshift;

`ifdef PS2SEQ_REPEAT_FILTER_EN
   logic       held_vld;
   logic [8:0] held_key;

   // Repeat make of the currently held key is consumed silently
   assign rpt_drop = !brk && held_vld && (held_key == {ext, rx_data});

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         held_vld <= 1'b0;
         held_key <= '0;
      end else if (take && byte_key) begin
         if (!brk) begin
            held_vld <= 1'b1;
            held_key <= {ext, rx_data};
         end else if (held_key == {ext, rx_data}) begin
            held_vld <= 1'b0;
         end
      end
   end
`else
   assign rpt_drop = 1'b0;
`endif

   // Decode FSM, modifier tracking and make-event counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= ST_IDLE;
         ext          <= 1'b0;
         brk          <= 1'b0;
         lshift       <= 1'b0;
         rshift       <= 1'b0;
         mod_ctrl     <= 1'b0;
         mod_alt      <= 1'b0;
         key_cnt      <= '0;
         rx_read_next <= 1'b0;
         err          <= 1'b0;
      end else begin
         rx_read_next <= 1'b0;
         err          <= 1'b0;
         case (state)
            ST_IDLE, ST_PFX: begin
               if (take) begin
                  rx_read_next <= 1'b1;
                  state        <= ST_GAP;
                  if (byte_err) begin
                     err <= 1'b1;
                     ext <= 1'b0;
                     brk <= 1'b0;
                  end else if (byte_ext) begin
                     ext <= 1'b1;
                  end else if (byte_brk) begin
                     brk <= 1'b1;
                  end else if (byte_key) begin
                     ext <= 1'b0;
                     brk <= 1'b0;
                     if (rx_data == SC_LSHIFT) lshift   <= !brk;
                     if (rx_data == SC_RSHIFT) rshift   <= !brk;
                     if (rx_data == SC_CTRL)   mod_ctrl <= !brk;
                     if (rx_data == SC_ALT)    mod_alt  <= !brk;
                     if (push && !brk) key_cnt <= key_cnt + CNT_W'(1);
                  end
               end
            end
            ST_GAP: state <= (ext || brk) ? ST_PFX : ST_IDLE;
            default: state <= ST_IDLE;
         endcase
         // Receiver overflow discards any partial prefix
         if (rx_overflow) begin
            err <= 1'b1;
            ext <= 1'b0;
            brk <= 1'b0;
            if (state != ST_GAP && !take) state <= ST_IDLE;
         end
      end
   end

   ps2_evt_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (EV_W)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .din   (push_data),
      .pop   (pop),
      .full  (fifo_full),
      .empty (fifo_empty),
      .head  (fifo_head)
   );

endmodule

// File: tb/tb_ps2_scan_sequencer.sv
// Directed bench for ps2_scan_sequencer (FIFO_DEPTH=2). A byte-queue model
// stands in for ps2key; a monitor records popped events and pulse counts.
// Event words are {brk, ext, code}.
module tb_ps2_scan_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx_ready = 1'b0;
   logic [7:0] rx_data = 8'h00;
   logic       rx_overflow = 1'b0;
   logic       rx_read_next;
   logic       ev_valid;
   logic       ev_ready = 1'b0;
   logic [7:0] ev_code;
   logic       ev_ext;
   logic       ev_break;
   logic       mod_shift;
   logic       mod_ctrl;
   logic       mod_alt;
   logic [7:0] key_cnt;
   logic       err;

   int ntests = 0;
   int nfail  = 0;
   int n_pulse = 0;
   int n_err   = 0;
   logic [7:0] byte_q[$];
   logic [9:0] obs_q[$];

   ps2_scan_sequencer #(.FIFO_DEPTH(2), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .rx_ready(rx_ready), .rx_data(rx_data),
      .rx_overflow(rx_overflow), .rx_read_next(rx_read_next),
      .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_code(ev_code),
      .ev_ext(ev_ext), .ev_break(ev_break), .mod_shift(mod_shift),
      .mod_ctrl(mod_ctrl), .mod_alt(mod_alt), .key_cnt(key_cnt), .err(err)
   );

   always #5 clk = ~clk;

   // ps2key stand-in: drops the head byte when the consume pulse is seen
   always @(posedge clk) begin
      #1;
      if (rx_read_next && byte_q.size() != 0) void'(byte_q.pop_front());
      rx_ready = (byte_q.size() != 0);
      rx_data  = (byte_q.size() != 0) ? byte_q[0] : 8'h00;
   end

   // Monitor: accepted events, consume pulses and error pulses
   always @(posedge clk) begin
      if (!rst) begin
         if (ev_valid && ev_ready) obs_q.push_back({ev_break, ev_ext, ev_code});
         if (rx_read_next) n_pulse++;
         if (err) n_err++;
      end
   end

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b1;
      byte_q.delete();
      ev_ready = 1'b0;
      rx_overflow = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      obs_q.delete();
      n_pulse = 0;
      n_err = 0;
   endtask

   task automatic send(input logic [7:0] b);
      byte_q.push_back(b);
   endtask

   task automatic settle(input string name);
      int i = 0;
      while (byte_q.size() != 0 && i < 200) begin
         @(posedge clk); #1;
         i++;
      end
      ntests++;
      if (byte_q.size() != 0) begin
         nfail++;
         $display("FAIL %s settle: %0d bytes left, required 0", name, byte_q.size());
      end
      repeat (6) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #2;
      ntests++;
      if ({rx_read_next, ev_valid, ev_code, ev_ext, ev_break, mod_shift,
           mod_ctrl, mod_alt, key_cnt, err} !== 24'h0) begin
         nfail++;
         $display("FAIL reset_outputs: got valid=%b code=%h cnt=%0d, required all 0",
                  ev_valid, ev_code, key_cnt);
      end
      do_reset();
   endtask

   task automatic test_make_break();
      do_reset();
      ev_ready = 1'b1;
      send(8'h1C); send(8'hF0); send(8'h1C);
      settle("make_break");
      ntests++;
      if (obs_q.size() != 2) begin
         nfail++; $display("FAIL mb_count: got %0d events, required 2", obs_q.size());
      end else begin
         ntests++;
         if (obs_q[0] !== 10'h01C) begin
            nfail++; $display("FAIL mb_ev0: got %h, required 01c", obs_q[0]);
         end
         ntests++;
         if (obs_q[1] !== 10'h21C) begin
            nfail++; $display("FAIL mb_ev1: got %h, required 21c", obs_q[1]);
         end
      end
      ntests++;
      if (key_cnt !== 8'd1) begin
         nfail++; $display("FAIL mb_key_cnt: got %0d, required 1", key_cnt);
      end
      ntests++;
      if (n_pulse != 3) begin
         nfail++; $display("FAIL mb_pulses: got %0d, required 3", n_pulse);
      end
   endtask

   task automatic test_ext_ctrl();
      do_reset();
      ev_ready = 1'b1;
      send(8'hE0); send(8'h14);
      settle("ext_make");
      ntests++;
      if (mod_ctrl !== 1'b1 || obs_q.size() != 1) begin
         nfail++; $display("FAIL ext_make: got ctrl=%b events=%0d, required ctrl=1 events=1",
                           mod_ctrl, obs_q.size());
      end else begin
         ntests++;
         if (obs_q[0] !== 10'h114) begin
            nfail++; $display("FAIL ext_ev0: got %h, required 114", obs_q[0]);
         end
      end
      send(8'hE0); send(8'hF0); send(8'h14);
      settle("ext_break");
      ntests++;
      if (mod_ctrl !== 1'b0 || obs_q.size() != 2) begin
         nfail++; $display("FAIL ext_break: got ctrl=%b events=%0d, required ctrl=0 events=2",
                           mod_ctrl, obs_q.size());
      end else begin
         ntests++;
         if (obs_q[1] !== 10'h314) begin
            nfail++; $display("FAIL ext_ev1: got %h, required 314", obs_q[1]);
         end
      end
      ntests++;
      if (key_cnt !== 8'd1 || n_err != 0) begin
         nfail++; $display("FAIL ext_cnt: got cnt=%0d err=%0d, required 1/0", key_cnt, n_err);
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      send(8'h12); send(8'h1C); send(8'h32);
      repeat (20) @(posedge clk);
      #1;
      ntests++;
      if (byte_q.size() != 1 || n_pulse != 2) begin
         nfail++; $display("FAIL bp_hold: got left=%0d pulses=%0d, required 1/2",
                           byte_q.size(), n_pulse);
      end
      ntests++;
      if (ev_valid !== 1'b1 || ev_code !== 8'h12 || mod_shift !== 1'b1) begin
         nfail++; $display("FAIL bp_head: got valid=%b code=%h shift=%b, required 1/12/1",
                           ev_valid, ev_code, mod_shift);
      end
      ev_ready = 1'b1;
      @(posedge clk); #1;
      ev_ready = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      ntests++;
      if (byte_q.size() != 0 || n_pulse != 3) begin
         nfail++; $display("FAIL bp_release: got left=%0d pulses=%0d, required 0/3",
                           byte_q.size(), n_pulse);
      end
      ev_ready = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      ntests++;
      if (obs_q.size() != 3) begin
         nfail++; $display("FAIL bp_count: got %0d events, required 3", obs_q.size());
      end else begin
         ntests++;
         if (obs_q[0] !== 10'h012 || obs_q[1] !== 10'h01C || obs_q[2] !== 10'h032) begin
            nfail++; $display("FAIL bp_order: got %h %h %h, required 012 01c 032",
                              obs_q[0], obs_q[1], obs_q[2]);
         end
      end
      ntests++;
      if (key_cnt !== 8'd3) begin
         nfail++; $display("FAIL bp_key_cnt: got %0d, required 3", key_cnt);
      end
   endtask

   task automatic test_proto_err();
      do_reset();
      ev_ready = 1'b1;
      send(8'hE0); send(8'hE0);
      settle("err_e0e0");
      ntests++;
      if (n_err != 1 || obs_q.size() != 0 || n_pulse != 2) begin
         nfail++; $display("FAIL err_e0e0: got err=%0d events=%0d pulses=%0d, required 1/0/2",
                           n_err, obs_q.size(), n_pulse);
      end
      send(8'hF0); send(8'hE0); send(8'h1C);
      settle("err_f0e0");
      ntests++;
      if (n_err != 2 || obs_q.size() != 1) begin
         nfail++; $display("FAIL err_f0e0: got err=%0d events=%0d, required 2/1",
                           n_err, obs_q.size());
      end else begin
         ntests++;
         if (obs_q[0] !== 10'h01C) begin
            nfail++; $display("FAIL err_recover: got %h, required 01c", obs_q[0]);
         end
      end
   endtask

   task automatic test_overflow();
      do_reset();
      ev_ready = 1'b1;
      send(8'hAA); send(8'hE0);
      settle("ovf_pfx");
      rx_overflow = 1'b1;
      @(posedge clk); #1;
      rx_overflow = 1'b0;
      send(8'h1C);
      settle("ovf_key");
      ntests++;
      if (n_err != 1 || obs_q.size() != 1 || n_pulse != 3) begin
         nfail++; $display("FAIL ovf: got err=%0d events=%0d pulses=%0d, required 1/1/3",
                           n_err, obs_q.size(), n_pulse);
      end else begin
         ntests++;
         if (obs_q[0] !== 10'h01C) begin
            nfail++; $display("FAIL ovf_ev: got %h, required 01c", obs_q[0]);
         end
      end
   endtask

   task automatic test_repeat();
      int exp_n;
      int exp_cnt;
`ifdef PS2SEQ_REPEAT_FILTER_EN
      exp_n = 2; exp_cnt = 1;
`else
      exp_n = 4; exp_cnt = 3;
`endif
      do_reset();
      ev_ready = 1'b1;
      send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C);
      settle("repeat");
      ntests++;
      if (obs_q.size() != exp_n || key_cnt !== 8'(exp_cnt)) begin
         nfail++; $display("FAIL repeat: got events=%0d cnt=%0d, required %0d/%0d",
                           obs_q.size(), key_cnt, exp_n, exp_cnt);
      end else begin
         ntests++;
         if (obs_q[exp_n-1] !== 10'h21C) begin
            nfail++; $display("FAIL repeat_last: got %h, required 21c", obs_q[exp_n-1]);
         end
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      send(8'h14); send(8'hE0);
      settle("rm_pre");
      ntests++;
      if (mod_ctrl !== 1'b1 || ev_valid !== 1'b1 || key_cnt !== 8'd1) begin
         nfail++; $display("FAIL rm_pre: got ctrl=%b valid=%b cnt=%0d, required 1/1/1",
                           mod_ctrl, ev_valid, key_cnt);
      end
      #2;
      rst = 1'b1;
      #1;
      ntests++;
      if ({rx_read_next, ev_valid, ev_code, ev_ext, ev_break, mod_shift,
           mod_ctrl, mod_alt, key_cnt, err} !== 24'h0) begin
         nfail++; $display("FAIL rm_async: got valid=%b ctrl=%b cnt=%0d, required all 0",
                           ev_valid, mod_ctrl, key_cnt);
      end
      do_reset();
      ev_ready = 1'b1;
      send(8'h1C);
      settle("rm_post");
      ntests++;
      if (obs_q.size() != 1) begin
         nfail++; $display("FAIL rm_count: got %0d events, required 1", obs_q.size());
      end else begin
         ntests++;
         if (obs_q[0] !== 10'h01C) begin
            nfail++; $display("FAIL rm_ev: got %h, required 01c", obs_q[0]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_make_break();
      test_ext_ctrl();
      test_backpressure();
      test_proto_err();
      test_overflow();
      test_repeat();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
